// File: rtl/iter_muldiv_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// iterative multiply/divide engine.
interface iter_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring)
// engine; one result bit per cycle, 2*WIDTH result returned as hi/lo.
module iter_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  iter_muldiv_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_path_q, dz_path_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [W2-1:0]      mul_next, div_next;
  logic               div_fits;
  logic [WIDTH-1:0]   rem_sub;
  logic [W2-1:0]      prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Datapath helpers: magnitudes, one iteration of each algorithm, sign fix-up
  always_comb begin
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, m_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};

    // Shifted partial remainder needs WIDTH+1 bits before the trial subtract
    div_fits  = acc_q[W2-1:WIDTH-1] >= {1'b0, m_q};
    rem_sub   = WIDTH'(acc_q[W2-1:WIDTH-1] - {1'b0, m_q});
    div_next  = div_fits ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[W2-2:0], 1'b0};

    prod_fix  = neg_q  ? -acc_q : acc_q;
    quo_fix   = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_path_d = dz_path_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            op_d    = bus.op;
            a_d     = bus.a;
            b_d     = bus.b;
            dz_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          neg_d     = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d    = is_signed & a_q[WIDTH-1];
          cnt_d     = '0;
          m_d       = is_div ? b_mag : a_mag;
          acc_d     = is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          dz_path_d = is_div && (b_q == '0);
          state_d   = (is_div && (b_q == '0)) ? S_FIX : S_RUN;
        end
        S_RUN: begin
          acc_d = is_div ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (dz_path_q) begin
            hi_d = a_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else if (is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_path_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_path_q <= dz_path_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed-vector bench for iter_muldiv_unit: arithmetic results, latency,
// back-to-back, operand hold, abort and asynchronous reset.
module tb_iter_muldiv_unit;
  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iter_muldiv_unit_if #(.WIDTH(W)) bus ();

  iter_muldiv_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for done; returns edges from accept to done
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb, output int lat, output int busy_cyc,
                        output logic dz_at_accept);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick;
    bus.start    = 1'b0;
    dz_at_accept = bus.div_by_zero;
    lat      = 0;
    busy_cyc = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cyc++;
      if (disturb) begin
        bus.start = ~bus.start;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom);
      end
      tick;
      lat++;
    end
    bus.start = 1'b0;
    if (lat >= 100) check_eq("done_timeout", 32'(bus.done), 32'd1);
  endtask

  int   lat, bcyc, done_seen;
  logic dza;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_dz",   32'(bus.div_by_zero), 32'd0);
    check_eq("rst_hi",   bus.hi, 32'd0);
    check_eq("rst_lo",   bus.lo, 32'd0);
    rst_n = 1'b1;
    tick;

    run_op(2'b00, 32'hFFFF_FFF9, 32'd6, 1'b0, lat, bcyc, dza);
    check_eq("smul_lat",  32'(lat),  32'd34);
    check_eq("smul_busy", 32'(bcyc), 32'd34);
    check_eq("smul_hi",   bus.hi, 32'hFFFF_FFFF);
    check_eq("smul_lo",   bus.lo, 32'hFFFF_FFD6);
    check_eq("done_busy_low", 32'(bus.busy), 32'd0);

    // issued in the done cycle of the previous op
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcyc, dza);
    check_eq("b2b_lat", 32'(lat), 32'd34);
    check_eq("umul_hi", bus.hi, 32'hFFFF_FFFE);
    check_eq("umul_lo", bus.lo, 32'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcyc, dza);
    check_eq("smul_m1_hi", bus.hi, 32'h0000_0000);
    check_eq("smul_m1_lo", bus.lo, 32'h0000_0001);

    run_op(2'b10, 32'hFFFF_FFEF, 32'd5, 1'b0, lat, bcyc, dza);
    check_eq("sdiv_lat", 32'(lat), 32'd34);
    check_eq("sdiv_lo",  bus.lo, 32'hFFFF_FFFD);
    check_eq("sdiv_hi",  bus.hi, 32'hFFFF_FFFE);

    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, bcyc, dza);
    check_eq("sdiv2_lo", bus.lo, 32'hFFFF_FFFD);
    check_eq("sdiv2_hi", bus.hi, 32'h0000_0001);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcyc, dza);
    check_eq("minm1_lo", bus.lo, 32'h8000_0000);
    check_eq("minm1_hi", bus.hi, 32'h0000_0000);
    check_eq("minm1_dz", 32'(bus.div_by_zero), 32'd0);

    run_op(2'b11, 32'd100, 32'd0, 1'b0, lat, bcyc, dza);
    check_eq("dz_lat", 32'(lat), 32'd2);
    check_eq("dz_lo",  bus.lo, 32'hFFFF_FFFF);
    check_eq("dz_hi",  bus.hi, 32'd100);
    check_eq("dz_flag", 32'(bus.div_by_zero), 32'd1);

    run_op(2'b01, 32'd3, 32'd5, 1'b0, lat, bcyc, dza);
    check_eq("dz_clear_at_accept", 32'(dza), 32'd0);
    check_eq("umul35_lo", bus.lo, 32'd15);
    check_eq("umul35_hi", bus.hi, 32'd0);

    // inputs scrambled and start toggled while busy
    run_op(2'b00, 32'd12, 32'hFFFF_FFFD, 1'b1, lat, bcyc, dza);
    check_eq("hold_lat", 32'(lat), 32'd34);
    check_eq("hold_lo",  bus.lo, 32'hFFFF_FFDC);
    check_eq("hold_hi",  bus.hi, 32'hFFFF_FFFF);

    // abort during RUN iteration 10
    bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (11) tick;
    check_eq("pre_abort_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.done) done_seen++;
    end
    check_eq("abort_no_done", 32'(done_seen), 32'd0);
    check_eq("abort_hold_lo", bus.lo, 32'hFFFF_FFDC);
    check_eq("abort_hold_hi", bus.hi, 32'hFFFF_FFFF);

    // abort wins over start in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    tick;
    bus.start = 1'b0; bus.abort = 1'b0;
    check_eq("abort_start_idle", 32'(bus.busy), 32'd0);
    tick;
    check_eq("abort_start_idle2", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-RUN
    bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (5) tick;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_done", 32'(bus.done), 32'd0);
    check_eq("mid_rst_hi",   bus.hi, 32'd0);
    check_eq("mid_rst_lo",   bus.lo, 32'd0);
    rst_n = 1'b1;
    tick;

    run_op(2'b11, 32'd1000, 32'd7, 1'b0, lat, bcyc, dza);
    check_eq("post_rst_lat", 32'(lat), 32'd34);
    check_eq("post_rst_lo",  bus.lo, 32'd142);
    check_eq("post_rst_hi",  bus.hi, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iter_muldiv_unit.md
Name: iter_muldiv_unit

Overview:
- Multi-cycle signed/unsigned multiply and divide engine for the bus-based CPU datapath.
- Replaces the single-cycle MUL/DIV paths in the ALU.
- Operands come from the Y register and BusMuxOut; the 2*WIDTH result is delivered as hi/lo to the Zhigh/Zlow registers.
- The control unit sequences the block with a start/busy/done handshake; width is parametrised.

Parameters:
- WIDTH, 32, operand width in bits (even, >= 4); result is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL signed, 01 MUL unsigned, 10 DIV signed, 11 DIV unsigned
- a  in  WIDTH  multiplicand / dividend (Y register)
- b  in  WIDTH  multiplier / divisor (BusMuxOut)
- abort  in  1  synchronous cancel of the in-flight operation
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; hi/lo valid from this cycle
- hi  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
- lo  out  WIDTH  MUL: product[W-1:0]; DIV: quotient
- div_by_zero  out  1  sticky flag for last DIV with b==0; cleared by the next accepted start

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - busy, done, div_by_zero, hi, lo = 0.
  - Internal accumulators and counter cleared.
- States: IDLE, PREP, RUN, FIX.
- IDLE:
  - On start==1 at an edge, latch a, b and op, then go to PREP. busy=1 from this edge.
  - div_by_zero is cleared at this edge.
  - done is driven 0 except in the cycle after FIX.
- PREP (1 cycle):
  - Signed ops: record the sign of each operand and replace operands by their magnitudes. Magnitude of the most negative value is its unsigned bit pattern (2^(W-1)).
  - Unsigned ops: pass operands through.
  - Counter=0.
  - DIV with b==0: go directly to FIX with the zero-divide path.
  - Otherwise go to RUN.
- RUN (exactly WIDTH cycles, one bit per cycle; counter increments; leave when counter==WIDTH-1):
  - MUL: radix-2 shift-add on unsigned magnitudes into a 2W accumulator.
  - DIV: restoring division; remainder shift-in, trial subtract, quotient bit set if no borrow.
- FIX (1 cycle), edge out of FIX:
  - Write hi/lo, pulse done=1 for the following cycle, deassert busy, return to IDLE.
  - Signed MUL: negate the 2W product if the operand signs differ.
  - Signed DIV: quotient negated if the signs differ (truncation toward zero); remainder takes the sign of the dividend.
  - MIN / -1 signed yields lo=MIN, hi=0 with no flag.
  - Zero-divide path: lo=all ones, hi=a, div_by_zero=1.
- Latency:
  - Accept edge E0. done is high in the cycle after edge E0+WIDTH+2 (i.e. WIDTH+2 edges after acceptance).
  - Zero-divide path: E0+2.
- busy:
  - High from E0 through the edge that raises done; low in the done cycle.
  - A new start in the done cycle is accepted (back-to-back ops supported).
- start while busy: ignored; no queueing; latched operands unaffected by changes on a/b/op after E0.
- abort:
  - In PREP/RUN/FIX, return to IDLE at the next edge with busy=0. No done pulse; hi/lo and div_by_zero hold their previous values.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins, request not accepted.
- hi/lo hold the last completed result until the next FIX write.
- reset asserted mid-operation: immediate return to reset values, with no done pulse.

Test Plan:
- WIDTH=32, op=00, a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42). done exactly 34 edges after accept; busy high for 34 cycles.
- op=01, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same op with op=00 -> hi=0, lo=1.
- op=10: a=-17, b=5 -> lo=-3 (0xFFFFFFFD), hi=-2 (0xFFFFFFFE). a=0x80000000, b=-1 -> lo=0x80000000, hi=0, div_by_zero=0.
- op=11, a=100, b=0 -> done 2 edges after accept, lo=0xFFFFFFFF, hi=100, div_by_zero=1. Next accepted start clears div_by_zero at its accept edge.
- Back-to-back and hold:
  - start in the done cycle of the previous op is accepted.
  - start pulses and operand changes during busy are ignored; the result matches the originally latched operands.
- Abort and reset:
  - abort at RUN iteration 10 -> IDLE next edge, no done, hi/lo retain the prior result.
  - reset pulled low mid-RUN -> all outputs 0 asynchronously; after release, a fresh op completes normally.
